// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: two-port (instruction read / data read-write) controller for
// an asynchronous external SRAM. Each WORD_W request is split into big-endian
// SRAM_W beats, each beat being one SETUP cycle followed by WAIT_CYC ACCESS
// cycles. Optional one-entry instruction buffer: define SRAM_ARB_IBUF_EN.
module sram_arb_ctrl #(
    parameter int WORD_W    = 32,
    parameter int SRAM_W    = 16,
    parameter int ADDR_W    = 23,
    parameter int WAIT_CYC  = 3,
    parameter int DATA_PRIO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic [WORD_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [WORD_W/8-1:0]   d_be,
    input  logic [31:0]           d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  busy,
    output logic [ADDR_W-1:0]     sram_addr,
    input  logic [SRAM_W-1:0]     sram_dq_i,
    output logic [SRAM_W-1:0]     sram_dq_o,
    output logic                  sram_dq_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [SRAM_W/8-1:0]   sram_be_n
);

    localparam int BEATS   = WORD_W / SRAM_W;
    localparam int BE_W    = WORD_W / 8;
    localparam int LANE_W  = SRAM_W / 8;
    localparam int LB      = $clog2(LANE_W);
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WAIT_CW = $clog2(WAIT_CYC);

    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [WAIT_CW-1:0] LAST_WAIT = WAIT_CW'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 sel_data_q, sel_data_d;   // 1 = data port owns the transfer
    logic                 we_q, we_d;
    logic [BE_W-1:0]      be_q, be_d;               // shifted left one beat at a time
    logic [WORD_W-1:0]    wdata_q, wdata_d;         // shifted left one beat at a time
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BEAT_CW-1:0]   beat_q, beat_d;
    logic [WAIT_CW-1:0]   wait_q, wait_d;
    logic [WORD_W-1:0]    rbuf_q, rbuf_d;           // read beats shift in at the LSB end
    logic [WORD_W-1:0]    i_rdata_q, i_rdata_d;
    logic [WORD_W-1:0]    d_rdata_q, d_rdata_d;

    logic                 grant_i, grant_d;
    logic                 last_wait, last_beat;

    // Byte address with the within-word offset cleared.
    function automatic logic [31:0] word_base(input logic [31:0] a);
        word_base = a & ~(32'(BE_W) - 32'd1);
    endfunction

    // SRAM word address of beat 0 for a byte address.
    function automatic logic [ADDR_W-1:0] beat0_addr(input logic [31:0] a);
        beat0_addr = ADDR_W'(word_base(a) >> LB);
    endfunction

    assign grant_d   = d_req && (!i_req || (DATA_PRIO != 0));
    assign grant_i   = i_req && !grant_d;
    assign last_wait = (wait_q == LAST_WAIT);
    assign last_beat = (beat_q == LAST_BEAT);

`ifdef SRAM_ARB_IBUF_EN
    logic                 ibuf_valid_q, ibuf_valid_d;
    logic [31:0]          ibuf_tag_q, ibuf_tag_d;
    logic [WORD_W-1:0]    ibuf_data_q, ibuf_data_d;
    logic [31:0]          req_tag_q, req_tag_d;     // base of the fetch in flight
    logic                 ibuf_hit;

    assign ibuf_hit = ibuf_valid_q && (ibuf_tag_q == word_base(i_addr));

    // Instruction buffer registers; cleared by reset so no stale hit survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ibuf_valid_q <= 1'b0;
            ibuf_tag_q   <= '0;
            ibuf_data_q  <= '0;
            req_tag_q    <= '0;
        end else begin
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_tag_q   <= ibuf_tag_d;
            ibuf_data_q  <= ibuf_data_d;
            req_tag_q    <= req_tag_d;
        end
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_data_q <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            beat_q     <= '0;
            wait_q     <= '0;
            rbuf_q     <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            wait_q     <= wait_d;
            rbuf_q     <= rbuf_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Next-state logic: arbitration in IDLE, beat/wait sequencing, read capture.
    always_comb begin
        state_d    = state_q;
        sel_data_d = sel_data_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        wait_d     = wait_q;
        rbuf_d     = rbuf_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef SRAM_ARB_IBUF_EN
        ibuf_valid_d = ibuf_valid_q;
        ibuf_tag_d   = ibuf_tag_q;
        ibuf_data_d  = ibuf_data_q;
        req_tag_d    = req_tag_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    sel_data_d = 1'b1;
                    we_d       = d_we;
                    be_d       = d_be;
                    wdata_d    = d_wdata;
                    addr_d     = beat0_addr(d_addr);
                    beat_d     = '0;
                    wait_d     = '0;
                    // A write with no lanes enabled touches nothing on the bus.
                    state_d    = (d_we && (d_be == '0)) ? DONE : SETUP;
`ifdef SRAM_ARB_IBUF_EN
                    if (d_we && (d_be != '0) && (word_base(d_addr) == ibuf_tag_q))
                        ibuf_valid_d = 1'b0;
`endif
                end else if (grant_i) begin
                    sel_data_d = 1'b0;
                    we_d       = 1'b0;
                    be_d       = '0;
                    addr_d     = beat0_addr(i_addr);
                    beat_d     = '0;
                    wait_d     = '0;
                    state_d    = SETUP;
`ifdef SRAM_ARB_IBUF_EN
                    req_tag_d  = word_base(i_addr);
                    if (ibuf_hit) begin
                        i_rdata_d = ibuf_data_q;
                        state_d   = DONE;
                    end
`endif
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (last_wait) begin
                    if (!we_q)
                        rbuf_d = (rbuf_q << SRAM_W) | WORD_W'(sram_dq_i);
                    if (last_beat) begin
                        state_d = DONE;
                        if (!we_q) begin
                            if (sel_data_q) begin
                                d_rdata_d = rbuf_d;
                            end else begin
                                i_rdata_d = rbuf_d;
`ifdef SRAM_ARB_IBUF_EN
                                ibuf_valid_d = 1'b1;
                                ibuf_tag_d   = req_tag_q;
                                ibuf_data_d  = rbuf_d;
`endif
                            end
                        end
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        addr_d  = addr_q + 1'b1;
                        wdata_d = wdata_q << SRAM_W;
                        be_d    = be_q << LANE_W;
                        state_d = SETUP;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM strobe decode from the registered state; we_n releases one cycle
    // early on writes so data stays driven through the hold cycle.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        sram_be_n  = '1;
        case (state_q)
            SETUP: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = we_q;
                sram_be_n  = we_q ? ~be_q[BE_W-1 -: LANE_W] : '0;
            end
            ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = we_q;
                sram_we_n  = !(we_q && !last_wait);
                sram_dq_oe = we_q;
                sram_be_n  = we_q ? ~be_q[BE_W-1 -: LANE_W] : '0;
            end
            default: ;
        endcase
    end

    assign sram_dq_o = wdata_q[WORD_W-1 -: SRAM_W];
    assign sram_addr = addr_q;
    assign busy      = (state_q != IDLE);
    assign i_ack     = (state_q == DONE) && !sel_data_q;
    assign d_ack     = (state_q == DONE) && sel_data_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl: acks are checked against a queue of
// expected (port, data, cycle) entries pushed when each request is issued.
module tb_sram_arb_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req, d_req, d_we, i_ack, d_ack, busy;
    logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata;
    logic [3:0]  d_be;
    logic [22:0] sram_addr;
    logic [15:0] sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [1:0]  sram_be_n;

    // second instance: instruction port wins ties
    logic        p_i_req, p_d_req, p_d_we, p_i_ack, p_d_ack, p_busy;
    logic [31:0] p_i_addr, p_d_addr, p_d_wdata, p_i_rdata, p_d_rdata;
    logic [3:0]  p_d_be;
    logic [22:0] p_addr;
    logic [15:0] p_dq_i, p_dq_o;
    logic        p_dq_oe, p_ce_n, p_oe_n, p_we_n;
    logic [1:0]  p_be_n;

    sram_arb_ctrl u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
        .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    sram_arb_ctrl #(.DATA_PRIO(0)) u_dut_p0 (
        .clk(clk), .rst(rst),
        .i_req(p_i_req), .i_addr(p_i_addr), .i_ack(p_i_ack), .i_rdata(p_i_rdata),
        .d_req(p_d_req), .d_we(p_d_we), .d_be(p_d_be), .d_addr(p_d_addr), .d_wdata(p_d_wdata),
        .d_ack(p_d_ack), .d_rdata(p_d_rdata), .busy(p_busy),
        .sram_addr(p_addr), .sram_dq_i(p_dq_i), .sram_dq_o(p_dq_o),
        .sram_dq_oe(p_dq_oe), .sram_ce_n(p_ce_n), .sram_oe_n(p_oe_n),
        .sram_we_n(p_we_n), .sram_be_n(p_be_n)
    );

    // SRAM model for the main instance: byte-laned writes, data only while oe_n low
    logic [15:0] mem [0:1023];
    logic        mem_init = 1'b0;
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 1024; k++) mem[k] = 16'(k) ^ 16'h5A5A;
            mem[10'h080] = 16'h1234;
            mem[10'h081] = 16'hABCD;
            mem[10'h100] = 16'h1111;
            mem[10'h101] = 16'h2222;
            mem_init = 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_be_n[1]) mem[sram_addr[9:0]][15:8] = sram_dq_o[15:8];
            if (!sram_be_n[0]) mem[sram_addr[9:0]][7:0]  = sram_dq_o[7:0];
        end
    end

    // pattern SRAM for the second instance
    assign p_dq_i = (!p_ce_n && !p_oe_n) ? {p_addr[7:0], ~p_addr[7:0]} : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];

    int          ce_cnt, oe_cnt, we_cnt;
    logic [1:0]  be_at [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, req);
        end
    endtask

    task automatic flag(input string tag);
        total++;
        bad++;
        $error("FAIL %s: bound expired before completion", tag);
    endtask

    task automatic check_ack(input bit is_d, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_ack: got port %0d ack at cycle %0d, expected none", is_d, cyc);
        end else begin
            e = sb.pop_front();
            chk("ack_port", {31'b0, is_d}, {31'b0, e.is_d});
            chk("ack_data", data, e.data);
            chk("ack_cycle", 32'(cyc), 32'(e.at));
            $display("ack port=%0d data=%h cycle=%0d", is_d, data, cyc);
        end
    endtask

    // monitor: strobe counters, write lane log, scoreboard pop on ack
    always @(negedge clk) begin
        if (!rst) begin
            if (!sram_ce_n) ce_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) begin
                we_cnt++;
                be_at[sram_addr[9:0]] = sram_be_n;
            end
            if (i_ack) check_ack(1'b0, i_rdata);
            if (d_ack) check_ack(1'b1, d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] data, input int lat);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        e.at   = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_sb(input int left, input int budget);
        int n = 0;
        while (sb.size() > left && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > left) begin
            flag("ack_timeout");
            while (sb.size() > left) void'(sb.pop_front());
        end
    endtask

    task automatic clr_cnt();
        ce_cnt = 0;
        oe_cnt = 0;
        we_cnt = 0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] data, input int lat);
        clr_cnt();
        i_addr = a;
        i_req  = 1'b1;
        push_exp(1'b0, data, lat);
        wait_sb(0, 40);
        i_req  = 1'b0;
        tick();
    endtask

    task automatic dacc(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata, input int lat);
        clr_cnt();
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        push_exp(1'b1, rdata, lat);
        wait_sb(0, 40);
        d_req   = 1'b0;
        tick();
    endtask

`ifdef SRAM_ARB_IBUF_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_CE  = 0;
`else
    localparam int HIT_LAT = 9;
    localparam int HIT_CE  = 8;
`endif

    initial begin
        int issue, ia, da;
        logic [31:0] ir, dr;

        rst = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        p_i_req = 0; p_i_addr = 0; p_d_req = 0; p_d_we = 0; p_d_be = 0; p_d_addr = 0; p_d_wdata = 0;
        clr_cnt();
        repeat (3) tick();

        // reset state
        chk("rst_i_ack", {31'b0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("rst_be_n", {30'b0, sram_be_n}, 32'd3);
        chk("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("rst_addr", {9'b0, sram_addr}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // instruction read
        fetch(32'h100, 32'h1234ABCD, 9);
        chk("rd_oe_cycles", 32'(oe_cnt), 32'd6);
        chk("rd_ce_cycles", 32'(ce_cnt), 32'd8);
        chk("rd_we_cycles", 32'(we_cnt), 32'd0);

        // data read, then byte-enabled write leaves d_rdata alone
        dacc(1'b0, 4'hF, 32'h104, 32'h0, 32'h5AD85AD9, 9);
        dacc(1'b1, 4'b0110, 32'h200, 32'hDEADBEEF, 32'h5AD85AD9, 9);
        chk("wr_we_cycles", 32'(we_cnt), 32'd4);
        chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        chk("wr_be_beat0", {30'b0, be_at[10'h100]}, 32'd2);
        chk("wr_be_beat1", {30'b0, be_at[10'h101]}, 32'd1);
        chk("wr_mem0", {16'b0, mem[10'h100]}, 32'h11AD);
        chk("wr_mem1", {16'b0, mem[10'h101]}, 32'hBE22);
        dacc(1'b0, 4'hF, 32'h200, 32'h0, 32'h11ADBE22, 9);

        // simultaneous requests, data port wins
        clr_cnt();
        i_addr = 32'h108; d_addr = 32'h10C; d_we = 1'b0; d_be = 4'hF;
        i_req = 1'b1; d_req = 1'b1;
        push_exp(1'b1, 32'h5ADC5ADD, 9);
        push_exp(1'b0, 32'h5ADE5ADF, 19);
        wait_sb(1, 40);
        d_req = 1'b0;
        wait_sb(0, 40);
        i_req = 1'b0;
        tick();

        // write with no byte lanes: immediate ack, no bus cycle
        dacc(1'b1, 4'b0000, 32'h104, 32'hFFFFFFFF, 32'h5ADC5ADD, 1);
        chk("be0_ce_cycles", 32'(ce_cnt), 32'd0);
        chk("be0_mem", {16'b0, mem[10'h082]}, 32'h5AD8);

        // instruction priority instance: i first at +9, d at +19
        p_i_addr = 32'h10; p_d_addr = 32'h20; p_d_we = 1'b0; p_d_be = 4'hF;
        p_i_req = 1'b1; p_d_req = 1'b1;
        issue = cyc; ia = -1; da = -1; ir = '0; dr = '0;
        for (int n = 0; n < 40 && (ia < 0 || da < 0); n++) begin
            tick();
            if (p_i_ack && ia < 0) begin ia = cyc; ir = p_i_rdata; p_i_req = 1'b0; end
            if (p_d_ack && da < 0) begin da = cyc; dr = p_d_rdata; p_d_req = 1'b0; end
        end
        p_i_req = 1'b0; p_d_req = 1'b0;
        chk("p0_i_lat", 32'(ia - issue), 32'd9);
        chk("p0_d_lat", 32'(da - issue), 32'd19);
        chk("p0_i_data", ir, 32'h08F709F6);
        chk("p0_d_data", dr, 32'h10EF11EE);
        $display("prio0 i_ack cycle=%0d d_ack cycle=%0d", ia - issue, da - issue);
        tick();

        // repeated fetch, then write to the same word and fetch again
        fetch(32'h40, 32'h5A7A5A7B, 9);
        fetch(32'h40, 32'h5A7A5A7B, HIT_LAT);
        chk("refetch_ce_cycles", 32'(ce_cnt), 32'(HIT_CE));
        dacc(1'b1, 4'hF, 32'h40, 32'hCAFEF00D, 32'h5ADC5ADD, 9);
        fetch(32'h40, 32'hCAFEF00D, 9);
        chk("after_wr_ce_cycles", 32'(ce_cnt), 32'd8);

        // reset during the second ACCESS cycle of beat 1
        i_addr = 32'h300;
        i_req  = 1'b1;
        issue  = cyc;
        repeat (7) tick();
        chk("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_req = 1'b0;
        chk("mid_elapsed", 32'(cyc - issue), 32'd8);
        @(negedge clk);
        chk("mid_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("mid_be_n", {30'b0, sram_be_n}, 32'd3);
        chk("mid_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        chk("mid_busy_after", {31'b0, busy}, 32'd0);
        chk("mid_i_ack", {31'b0, i_ack}, 32'd0);
        chk("mid_i_rdata", i_rdata, 32'd0);
        chk("mid_d_rdata", d_rdata, 32'd0);
        tick();
        repeat (3) tick();

        // full access again after reset
        fetch(32'h100, 32'h1234ABCD, 9);
        chk("post_rst_ce_cycles", 32'(ce_cnt), 32'd8);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Parametrised controller for asynchronous external SRAM with two requester ports: instruction (read-only) and data (read/write, byte-enabled).
- Arbitrates between the ports and splits each WORD_W word into SRAM_W-wide beats.
- Drives SRAM strobes with programmable wait states.
- Sits between CPU fetch/memory stages and board SRAM pins; uses per-port req/ack handshakes instead of a global stall.

Parameters:
- WORD_W, 32: requester word width; integer multiple of SRAM_W.
- SRAM_W, 16: SRAM data bus width; multiple of 8.
- ADDR_W, 23: SRAM word-address width.
- WAIT_CYC, 3: access cycles per beat; legal range >= 2.
- DATA_PRIO, 1: on simultaneous requests, 1 = data port wins, 0 = instruction port wins.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset.
- i_req  in  1  instruction read request; held until i_ack.
- i_addr  in  32  instruction byte address.
- i_ack  out  1  one-cycle completion pulse.
- i_rdata  out  WORD_W  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  WORD_W/8  byte enables for writes; MSB = byte at the lowest address.
- d_addr  in  32  data byte address.
- d_wdata  in  WORD_W  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  WORD_W  read word.
- busy  out  1  controller not IDLE.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_dq_i  in  SRAM_W  SRAM data in.
- sram_dq_o  out  SRAM_W  SRAM data out.
- sram_dq_oe  out  1  pad output enable.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low strobes.
- sram_be_n  out  SRAM_W/8  active-low byte lanes.

Behaviour:
- Reset: rst is synchronous, active-high. Applying it returns the FSM to IDLE at the next edge and sets:
  - acks and busy = 0; i_rdata and d_rdata = 0.
  - ce_n, oe_n, we_n = 1; be_n all 1; dq_oe = 0; sram_addr = 0.
  - Reset mid-transfer aborts without an ack; the partial rdata is discarded.
- Derived values:
  - BEATS = WORD_W/SRAM_W.
  - LB = log2(SRAM_W/8).
  - Word base = addr with its low log2(WORD_W/8) bits cleared.
  - Beat k (k = 0..BEATS-1) address = (base >> LB) + k, truncated to ADDR_W. Wrap at 2^ADDR_W is silent.
- Beat order: beat 0 carries the most-significant SRAM_W bits (big-endian).
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: samples i_req and d_req. If neither is set, stay. If one is set, grant it. If both are set, grant per DATA_PRIO. Grant latches address, we, be and wdata, then go to SETUP.
  - SETUP (1 cycle): ce_n = 0, address valid, oe_n = 1, we_n = 1. On a write, dq_oe = 1 and dq_o = beat data.
  - ACCESS (WAIT_CYC cycles), counted by the wait counter:
    - Read: oe_n = 0; sram_dq_i captured into the beat slice on the final ACCESS cycle.
    - Write: we_n = 0 for the first WAIT_CYC-1 cycles and 1 on the final cycle. dq_o and dq_oe are held through the final cycle to give data hold time.
    - be_n = ~(beat slice of d_be) on writes; all 0 on reads.
    - After the final cycle: if beats remain, go to SETUP for the next beat; otherwise go to DONE.
  - DONE (1 cycle): all strobes inactive; the granted port's ack = 1 and its rdata is updated; next state IDLE.
  - The new grant is sampled only in IDLE, so there are no back-to-back grants without an IDLE cycle.
- Latency: from the cycle req is sampled in IDLE to ack = BEATS*(1+WAIT_CYC)+1. With defaults this is 9.
- rdata is registered and holds its value until the next ack on the same port. d_rdata is unchanged after a write.
- A write with d_be all zero performs no SRAM cycle: IDLE -> DONE, d_ack one cycle after the grant.
- A requester dropping req before ack is illegal. The controller completes the transfer regardless and still pulses ack.
- The losing port keeps req asserted and is served in the next IDLE. Strict priority applies, with no starvation guarantee.

Optional Feature:
- Macro: SRAM_ARB_IBUF_EN.
- When defined: a one-entry instruction buffer holds a tag (word base), the data, and a valid bit.
  - A granted i_req whose base matches the tag with valid = 1 goes IDLE -> DONE: i_ack one cycle after the grant, no SRAM strobes.
  - A miss fills the buffer on completion.
  - Any data write (d_be nonzero) to a word whose base matches the tag clears valid.
  - rst clears valid.
- When undefined: every fetch accesses SRAM; no buffer registers exist.

Test Plan:
- Read, defaults: i_req, i_addr = 0x100, SRAM returns 0x1234 at addr 0x80 and 0xABCD at 0x81 -> i_ack at cycle 9, i_rdata = 0x1234ABCD, oe_n low 3 cycles per beat.
- Byte-enabled write: d_we = 1, d_addr = 0x200, d_wdata = 0xDEADBEEF, d_be = 0b0110 -> beat 0 at 0x100 with be_n = 10b, beat 1 at 0x101 with be_n = 01b, we_n low 2 cycles per beat, d_ack at cycle 9.
- Simultaneous requests, DATA_PRIO = 1, both held -> d_ack at cycle 9, i_ack at cycle 19; with DATA_PRIO = 0 the ack order is reversed.
- Reset mid-transfer: rst = 1 in the second ACCESS cycle of beat 1 -> next cycle all strobes high, dq_oe = 0, no ack, busy = 0, rdata = 0.
- d_be = 0 write -> d_ack one cycle after the grant; ce_n never asserted.
- IBUF (macro defined): fetch 0x40 twice -> second i_ack one cycle after the grant, no strobes. Then a write to 0x40 followed by a fetch of 0x40 -> full 9-cycle SRAM access.
